// File: rtl/reg_bank_seq_if.sv
// Purpose: request/operand/write-back signal bundle between a requester and reg_bank_seq.
// Latency: none (wires only).
// Backpressure: requester holds req_valid until it sees req_ready at a clock edge.
//
// Signals:
//   req_valid/req_ready   one-at-a-time request handshake
//   req_srca/srcb/dst/wb  operand A/B indices, write-back index, write-back flag
//   outenA/outenB/load    one-hot (or zero) register bus enables and load strobes
//   opnd_valid            operands on buses A/B this cycle
//   res_valid             result present on the register input bus
//   busy                  sequencer not idle
//   err_idx/err_timeout   single-cycle error pulses
interface reg_bank_seq_if #(
  parameter int NREG = 8,
  parameter int IDXW = 3
);
  logic            req_valid;
  logic            req_ready;
  logic [IDXW-1:0] req_srca;
  logic [IDXW-1:0] req_srcb;
  logic [IDXW-1:0] req_dst;
  logic            req_wb;
  logic [NREG-1:0] outenA;
  logic [NREG-1:0] outenB;
  logic [NREG-1:0] load;
  logic            opnd_valid;
  logic            res_valid;
  logic            busy;
  logic            err_idx;
  logic            err_timeout;

  // Requester side.
  modport master (
    output req_valid, req_srca, req_srcb, req_dst, req_wb, res_valid,
    input  req_ready, outenA, outenB, load, opnd_valid, busy, err_idx, err_timeout
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_srca, req_srcb, req_dst, req_wb, res_valid,
    output req_ready, outenA, outenB, load, opnd_valid, busy, err_idx, err_timeout
  );
endinterface

// File: rtl/reg_bank_seq.sv
// Purpose: sequences one register-bank operation at a time: operand read, wait for result, write-back.
// Latency: read 1 cycle after accept; load 1 cycle after res_valid; non-wb ops accept every 2 cycles.
// Backpressure: req_ready is high only in IDLE; one request in flight, no queueing.
//
// Ports:
//   clk, rst  rising-edge clock, synchronous active-high reset
//   bus       reg_bank_seq_if slave modport (request handshake, bus enables,
//             result strobe, busy and error pulses)
//
// All bus enables are decoded from state and latched fields only, so a
// late-arriving req_*/res_valid can never create a second driver on a
// tri-state bus within the same cycle.
module reg_bank_seq #(
  parameter int NREG       = 8,
  parameter int IDXW       = 3,
  parameter int WB_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  reg_bank_seq_if.slave bus
);

  // Counter only has to hold 0 .. WB_TIMEOUT-1.
  localparam int              CNTW     = (WB_TIMEOUT > 1) ? $clog2(WB_TIMEOUT) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WB_TIMEOUT - 1);

  // Index range check is done one bit wider so that NREG == 2**IDXW
  // compares correctly instead of truncating NREG to zero.
  localparam int              IDXW1  = IDXW + 1;
  localparam logic [IDXW:0]   NREG_W = IDXW1'(NREG);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            err_idx_q, err_idx_d;
  logic            err_to_q, err_to_d;

  logic [IDXW-1:0] srca_q, srcb_q, dst_q;
  logic            wb_q;

  logic            accept;
  logic            bad_idx;

  assign accept = (state_q == IDLE) && bus.req_valid;

  // dst only matters when the op actually writes back.
  assign bad_idx = ({1'b0, bus.req_srca} >= NREG_W) ||
                   ({1'b0, bus.req_srcb} >= NREG_W) ||
                   (bus.req_wb && ({1'b0, bus.req_dst} >= NREG_W));

  // ---------------------------------------------------------------------
  // State register, WAIT counter and error pulse flops
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      err_idx_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_idx_q <= err_idx_d;
      err_to_q  <= err_to_d;
    end
  end

  // Request fields are captured on every accepted request, including a
  // rejected one; a rejected request never leaves IDLE so the stale copy
  // is never decoded onto the buses.
  always_ff @(posedge clk) begin
    if (rst) begin
      srca_q <= '0;
      srcb_q <= '0;
      dst_q  <= '0;
      wb_q   <= 1'b0;
    end else if (accept) begin
      srca_q <= bus.req_srca;
      srcb_q <= bus.req_srcb;
      dst_q  <= bus.req_dst;
      wb_q   <= bus.req_wb;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    err_idx_d = 1'b0;
    err_to_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (bad_idx) begin
            err_idx_d = 1'b1;
          end else begin
            state_d = READ;
          end
        end
      end

      READ: begin
        state_d = wb_q ? WAIT : IDLE;
      end

      // res_valid is checked before the limit so a result arriving on the
      // final count cycle still gets written back.
      WAIT: begin
        if (bus.res_valid) begin
          state_d = WRITE;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = IDLE;
          err_to_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end

      WRITE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs: decoded from flops only. Each enable vector is a single
  // shifted bit or zero, so at most one driver per bus by construction.
  // ---------------------------------------------------------------------
  assign bus.outenA      = (state_q == READ)  ? (NREG'(1) << srca_q) : '0;
  assign bus.outenB      = (state_q == READ)  ? (NREG'(1) << srcb_q) : '0;
  assign bus.load        = (state_q == WRITE) ? (NREG'(1) << dst_q)  : '0;
  assign bus.opnd_valid  = (state_q == READ);
  assign bus.req_ready   = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.err_idx     = err_idx_q;
  assign bus.err_timeout = err_to_q;

endmodule

// File: tb/tb_reg_bank_seq.sv
// Purpose: self-checking bench for reg_bank_seq (8-register and 6-register instances).
// Latency: n/a.
// Backpressure: n/a.
module tb_reg_bank_seq;

  localparam int T = 15;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] ld;
    logic       ov;
    logic       busy;
    logic       rdy;
    logic       eidx;
    logic       eto;
  } exp_t;

  logic clk;
  logic rst;

  reg_bank_seq_if #(.NREG(8), .IDXW(3)) bus0 ();
  reg_bank_seq_if #(.NREG(6), .IDXW(3)) bus1 ();

  reg_bank_seq #(.NREG(8), .IDXW(3), .WB_TIMEOUT(T)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  reg_bank_seq #(.NREG(6), .IDXW(3), .WB_TIMEOUT(T)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t exp_cur;
  logic chk_on;
  logic pend_idx;
  logic pend_to;

  logic [7:0]  load_seen[$];
  logic [7:0]  exp_loads[$];
  logic [15:0] read_seen[$];
  int          to_cnt;
  int          run_len;
  int          last_run;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Per-cycle comparison of dut0 against the expected timeline, plus
  // observation logs used by the literal checks.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("outenA",      {24'd0, bus0.outenA}, {24'd0, exp_cur.a});
      chk("outenB",      {24'd0, bus0.outenB}, {24'd0, exp_cur.b});
      chk("load",        {24'd0, bus0.load},   {24'd0, exp_cur.ld});
      chk("opnd_valid",  {31'd0, bus0.opnd_valid},  {31'd0, exp_cur.ov});
      chk("busy",        {31'd0, bus0.busy},        {31'd0, exp_cur.busy});
      chk("req_ready",   {31'd0, bus0.req_ready},   {31'd0, exp_cur.rdy});
      chk("err_idx",     {31'd0, bus0.err_idx},     {31'd0, exp_cur.eidx});
      chk("err_timeout", {31'd0, bus0.err_timeout}, {31'd0, exp_cur.eto});
      chk("onehot_bus",  {31'd0, ($countones(bus0.outenA) <= 1) &&
                                 ($countones(bus0.outenB) <= 1) &&
                                 ($countones(bus0.load) <= 1)}, 32'd1);
      if (|bus0.load)       load_seen.push_back(bus0.load);
      if (bus0.opnd_valid)  read_seen.push_back({bus0.outenA, bus0.outenB});
      if (bus0.err_timeout) to_cnt++;
      if (bus0.busy) begin
        run_len++;
      end else if (run_len != 0) begin
        last_run = run_len;
        run_len  = 0;
      end
    end
  end

  // One clock cycle: inputs for this cycle, expected outputs during it.
  task automatic step(input exp_t e, input logic rv);
    bus0.res_valid = rv;
    exp_cur        = e;
    chk_on         = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Idle cycle; any error pulse owed by the previous op shows up here.
  task automatic idle_step(input logic rv);
    exp_t e;
    e      = '0;
    e.rdy  = 1'b1;
    e.eidx = pend_idx;
    e.eto  = pend_to;
    pend_idx = 1'b0;
    pend_to  = 1'b0;
    step(e, rv);
  endtask

  // Full operation on dut0. rdelay = index of the WAIT cycle carrying
  // res_valid; rdelay >= T means the result never comes.
  task automatic do_op(input int sa, input int sb, input int d, input logic wb, input int rdelay);
    exp_t e;
    bus0.req_valid = 1'b1;
    bus0.req_srca  = sa[2:0];
    bus0.req_srcb  = sb[2:0];
    bus0.req_dst   = d[2:0];
    bus0.req_wb    = wb;
    idle_step(1'($urandom_range(0, 1)));
    bus0.req_valid = 1'b0;
    bus0.req_srca  = 3'($urandom);
    bus0.req_srcb  = 3'($urandom);
    bus0.req_dst   = 3'($urandom);
    bus0.req_wb    = 1'($urandom);

    e      = '0;
    e.a    = 8'd1 << sa;
    e.b    = 8'd1 << sb;
    e.ov   = 1'b1;
    e.busy = 1'b1;
    step(e, 1'($urandom_range(0, 1)));
    if (!wb) return;

    for (int j = 0; j < T; j++) begin
      e      = '0;
      e.busy = 1'b1;
      step(e, j == rdelay);
      if (j == rdelay) begin
        e      = '0;
        e.busy = 1'b1;
        e.ld   = 8'd1 << d;
        step(e, 1'($urandom_range(0, 1)));
        exp_loads.push_back(8'd1 << d);
        return;
      end
    end
    pend_to = 1'b1;
  endtask

  // dut1 (NREG=6): drive one cycle, then check the cycle after the edge.
  task automatic d1(input string nm, input logic v, input int sa, input int sb, input int d,
                    input logic wb, input logic rv, input logic [5:0] ea, input logic [5:0] eb,
                    input logic [5:0] el, input logic eidx, input logic ebusy);
    bus1.req_valid = v;
    bus1.req_srca  = sa[2:0];
    bus1.req_srcb  = sb[2:0];
    bus1.req_dst   = d[2:0];
    bus1.req_wb    = wb;
    bus1.res_valid = rv;
    @(posedge clk);
    #1;
    chk({nm, ".outenA"},    {26'd0, bus1.outenA}, {26'd0, ea});
    chk({nm, ".outenB"},    {26'd0, bus1.outenB}, {26'd0, eb});
    chk({nm, ".load"},      {26'd0, bus1.load},   {26'd0, el});
    chk({nm, ".err_idx"},   {31'd0, bus1.err_idx},   {31'd0, eidx});
    chk({nm, ".busy"},      {31'd0, bus1.busy},      {31'd0, ebusy});
    chk({nm, ".req_ready"}, {31'd0, bus1.req_ready}, {31'd0, !ebusy});
  endtask

  initial begin
    exp_t e;
    int   n0;
    int   t0;
    int   sa, sb, d, rd;
    logic wb;

    rst = 1'b1;
    chk_on = 1'b0;
    pend_idx = 1'b0;
    pend_to = 1'b0;
    to_cnt = 0;
    run_len = 0;
    last_run = 0;
    exp_cur = '0;
    bus0.req_valid = 1'b0; bus0.req_srca = '0; bus0.req_srcb = '0;
    bus0.req_dst = '0; bus0.req_wb = 1'b0; bus0.res_valid = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_srca = '0; bus1.req_srcb = '0;
    bus1.req_dst = '0; bus1.req_wb = 1'b0; bus1.res_valid = 1'b0;

    @(posedge clk); #1;
    @(posedge clk); #1;
    // Reset state, held while rst is still high.
    e = '0; e.rdy = 1'b1;
    step(e, 1'b1);
    rst = 1'b0;
    idle_step(1'b0);

    // Read-only op, same register on both buses.
    n0 = load_seen.size();
    do_op(3, 3, 0, 1'b0, 0);
    idle_step(1'b0);
    chk("ro_read_pair", {16'd0, read_seen[$]}, 32'h0808);
    chk("ro_busy_len",  last_run, 1);
    chk("ro_no_load",   load_seen.size(), n0);

    // Write-back, result in the 2nd WAIT cycle.
    do_op(0, 7, 4, 1'b1, 1);
    idle_step(1'b0);
    chk("wb_read_pair", {16'd0, read_seen[$]}, 32'h0180);
    chk("wb_load",      {24'd0, load_seen[$]}, 32'h10);
    chk("wb_busy_len",  last_run, 4);

    // Write-back with result in the very last WAIT cycle: result wins.
    n0 = load_seen.size();
    do_op(6, 1, 2, 1'b1, T - 1);
    idle_step(1'b0);
    chk("late_load",     {24'd0, load_seen[$]}, 32'h04);
    chk("late_busy_len", last_run, T + 2);

    // Timeout: no result ever.
    n0 = load_seen.size();
    t0 = to_cnt;
    do_op(1, 2, 3, 1'b1, 99);
    idle_step(1'b0);
    idle_step(1'b0);
    chk("to_pulses",   to_cnt - t0, 1);
    chk("to_busy_len", last_run, 1 + T);
    chk("to_no_load",  load_seen.size(), n0);

    // Reset in the middle of WAIT, with res_valid arriving together with rst.
    n0 = load_seen.size();
    bus0.req_valid = 1'b1; bus0.req_srca = 3'd2; bus0.req_srcb = 3'd5;
    bus0.req_dst = 3'd1; bus0.req_wb = 1'b1;
    idle_step(1'b0);
    bus0.req_valid = 1'b0;
    e = '0; e.a = 8'h04; e.b = 8'h20; e.ov = 1'b1; e.busy = 1'b1;
    step(e, 1'b0);
    e = '0; e.busy = 1'b1;
    step(e, 1'b0);
    rst = 1'b1;
    step(e, 1'b1);
    rst = 1'b0;
    idle_step(1'b1);
    idle_step(1'b1);
    idle_step(1'b0);
    chk("rst_read_pair", {16'd0, read_seen[$]}, 32'h0420);
    chk("rst_no_load",   load_seen.size(), n0);

    // Back-to-back random ops with res_valid glitches outside WAIT.
    for (int i = 0; i < 40; i++) begin
      sa = $urandom_range(0, 7);
      sb = $urandom_range(0, 7);
      d  = $urandom_range(0, 7);
      wb = 1'($urandom_range(0, 1));
      rd = ($urandom_range(0, 7) == 0) ? 50 : $urandom_range(0, 3);
      do_op(sa, sb, d, wb, rd);
      if ($urandom_range(0, 3) == 0) idle_step(1'b1);
    end
    idle_step(1'b0);
    idle_step(1'b0);

    // Load order scoreboard.
    chk("load_count", load_seen.size(), exp_loads.size());
    for (int i = 0; i < exp_loads.size() && i < load_seen.size(); i++) begin
      chk("load_order", {24'd0, load_seen[i]}, {24'd0, exp_loads[i]});
    end
    chk_on = 1'b0;

    // NREG=6 instance: index range checking.
    d1("bad_srca",    1'b1, 6, 0, 0, 1'b0, 1'b0, 6'h00, 6'h00, 6'h00, 1'b1, 1'b0);
    d1("bad_clear",   1'b0, 0, 0, 0, 1'b0, 1'b0, 6'h00, 6'h00, 6'h00, 1'b0, 1'b0);
    d1("bad_srcb",    1'b1, 0, 7, 0, 1'b0, 1'b0, 6'h00, 6'h00, 6'h00, 1'b1, 1'b0);
    d1("bad_dst_wb",  1'b1, 1, 2, 6, 1'b1, 1'b0, 6'h00, 6'h00, 6'h00, 1'b1, 1'b0);
    d1("dst_nowb_ok", 1'b1, 5, 0, 6, 1'b0, 1'b0, 6'h20, 6'h01, 6'h00, 1'b0, 1'b1);
    d1("nowb_idle",   1'b0, 0, 0, 0, 1'b0, 1'b0, 6'h00, 6'h00, 6'h00, 1'b0, 1'b0);
    d1("wb5_read",    1'b1, 5, 5, 5, 1'b1, 1'b0, 6'h20, 6'h20, 6'h00, 1'b0, 1'b1);
    d1("wb5_wait",    1'b0, 0, 0, 0, 1'b0, 1'b1, 6'h00, 6'h00, 6'h00, 1'b0, 1'b1);
    d1("wb5_write",   1'b0, 0, 0, 0, 1'b0, 1'b1, 6'h00, 6'h00, 6'h20, 1'b0, 1'b1);
    d1("wb5_idle",    1'b0, 0, 0, 0, 1'b0, 1'b1, 6'h00, 6'h00, 6'h00, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
